axis_pha_run_controller: RTL
============================

Name: axis_pha_run_controller

Overview:
Sequences one pulse-height acquisition run around the pulse height analyzer output stream: start, clear histogram memory, acquire, stop.
- Sits between the analyzer's m_axis output and the histogram accumulator.
- Gates the pulse-height stream into the histogram only while a run is active.
- Drives a BRAM clear sweep before each run.
- Exposes real-time, event-count and state status for the PS.

Parameters:
AXIS_TDATA_WIDTH, 16, pulse-height sample width
BRAM_ADDR_WIDTH, 14, histogram address width; clear sweep covers 2^BRAM_ADDR_WIDTH words
TIME_WIDTH, 64, real-time counter and limit width
EVNT_WIDTH, 32, accepted-event counter and limit width

Ports:
aclk  in  1  clock
areset  in  1  asynchronous, active-high reset
cfg_start  in  1  level; rising edge requests a run
cfg_stop  in  1  level; rising edge requests abort/stop
cfg_time  in  TIME_WIDTH  real-time limit in aclk cycles; 0 = unlimited
cfg_events  in  EVNT_WIDTH  event limit; 0 = unlimited
sts_state  out  2  0 IDLE, 1 CLEAR, 2 RUN, 3 DONE
sts_time  out  TIME_WIDTH  RUN cycles elapsed
sts_events  out  EVNT_WIDTH  accepted events
bram_clr_addr  out  BRAM_ADDR_WIDTH  clear address
bram_clr_wren  out  1  clear write strobe; data is implicitly zero
s_axis_tready  out  1  slave ready
s_axis_tdata  in  AXIS_TDATA_WIDTH  pulse height
s_axis_tvalid  in  1  slave valid
m_axis_tready  in  1  master ready
m_axis_tdata  out  AXIS_TDATA_WIDTH  pulse height to histogram
m_axis_tvalid  out  1  master valid

Behaviour:
Reset and edge detection:
- Reset (async assert, sync-safe deassert): state IDLE; sts_time=0; sts_events=0; bram_clr_addr=0; bram_clr_wren=0.
- Edge-detect registers for cfg_start and cfg_stop reset to 0. A level held high across reset does not trigger.

IDLE / DONE:
- Start edge -> CLEAR. Zero sts_time, sts_events and bram_clr_addr on the transition.
- DONE holds the final counters until the next start.

CLEAR:
- bram_clr_wren=1 every cycle; bram_clr_addr increments by 1 per cycle.
- The cycle with addr = all-ones is the last write; next state is RUN, with addr wrapping to 0.
- Clear length is exactly 2^BRAM_ADDR_WIDTH cycles.
- Stop edge in CLEAR -> IDLE immediately; wren drops next cycle.

RUN:
- m_axis_tdata = s_axis_tdata, m_axis_tvalid = s_axis_tvalid, s_axis_tready = m_axis_tready (combinational, zero latency).
- sts_time += 1 every RUN cycle.
- sts_events += 1 per m_axis handshake (tvalid & tready).
- Terminate -> DONE when any of these holds:
  - stop edge;
  - cfg_time != 0 and sts_time + 1 == cfg_time (the run lasts exactly cfg_time cycles);
  - cfg_events != 0 and a handshake brings sts_events to cfg_events.
- The handshake on the terminating cycle is counted and forwarded.
- Limits are sampled live; a limit lowered below the current count does not terminate. Only equality terminates, and counting continues until stop.

Outside RUN:
- m_axis_tvalid=0; s_axis_tready=1, so upstream samples are sunk and discarded and the analyzer never stalls.

Other rules:
- Start edge in CLEAR or RUN is ignored.
- Simultaneous start and stop edges in IDLE/DONE: stop wins, state unchanged.
- Counters saturate at all-ones, no wrap.

Optional Feature:
PHA_DEADTIME_EN
- Defined: adds output sts_dead (TIME_WIDTH, reset 0, zeroed on start). It increments in each RUN cycle where s_axis_tvalid & ~m_axis_tready (histogram back-pressure), saturating.
- Not defined: port absent, no extra logic.

Decomposition:
- Package pha_ctrl_pkg: state enum (IDLE/CLEAR/RUN/DONE, 2-bit encoding as in sts_state) and the saturating-increment function.
- Sub-module pha_clear_sweep: the address sweep counter with a start input and a last flag, reusable by other histogram blocks.
- Everything else stays in the top module.

Test Plan:
- BRAM_ADDR_WIDTH=4, start edge -> 16 consecutive wren cycles, addr 0..15; RUN entered on cycle 17; sts_state=1 then 2.
- cfg_time=100, cfg_events=0, continuous valid, m_axis_tready=1 -> DONE after exactly 100 RUN cycles; sts_time=100; sts_events=100.
- cfg_time=0, cfg_events=5, sparse valid -> DONE on the 5th handshake; sts_events=5; 6th sample not forwarded; s_axis_tready=1 afterwards.
- Stop edge mid-CLEAR at addr 7 -> IDLE next cycle; wren=0; a later start restarts the sweep at addr 0.
- m_axis_tready=0 for 10 cycles with valid high in RUN -> s_axis_tready=0, no events counted; sts_dead=10 with PHA_DEADTIME_EN.
- areset asserted mid-RUN with cfg_start held high -> IDLE, counters 0; no new run until cfg_start goes low then high.

Source files
------------

// File: rtl/pha_ctrl_pkg.sv
// Shared types and helpers for the pulse-height acquisition run controller.
package pha_ctrl_pkg;

    localparam int unsigned STATE_W = 2;
    localparam int unsigned SAT_W   = 64;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_CLEAR = 2'd1;
    localparam logic [STATE_W-1:0] ST_RUN   = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE  = 2'd3;

    // Increment that sticks at max_v; callers widen to SAT_W and narrow the result back.
    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                                 input logic [SAT_W-1:0] max_v);
        return (v == max_v) ? v : v + SAT_W'(1);
    endfunction

endpackage

// File: rtl/pha_clear_sweep.sv
// Histogram BRAM clear sweep: walks every address once after start_i, flags the final word.
module pha_clear_sweep #(
    parameter int unsigned ADDR_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  abort_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  wren_o,
    output logic                  last_c
);

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  active_q, active_d;

    assign last_c = active_q & (&addr_q);
    assign addr_o = addr_q;
    assign wren_o = active_q;

    always_comb begin
        addr_d   = addr_q;
        active_d = active_q;
        if (abort_i) begin
            active_d = 1'b0;
            addr_d   = '0;
        end else if (start_i) begin
            active_d = 1'b1;
            addr_d   = '0;
        end else if (active_q) begin
            // Final word wraps the address back to zero for the next sweep.
            addr_d = addr_q + ADDR_WIDTH'(1);
            if (last_c) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            active_q <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/axis_pha_run_controller.sv
// Run sequencer around the PHA stream: IDLE -> CLEAR (BRAM sweep) -> RUN (gated stream) -> DONE.
// Optional macro PHA_DEADTIME_EN adds the sts_dead back-pressure counter.
module axis_pha_run_controller
    import pha_ctrl_pkg::*;
#(
    parameter int unsigned AXIS_TDATA_WIDTH = 16,
    parameter int unsigned BRAM_ADDR_WIDTH  = 14,
    parameter int unsigned TIME_WIDTH       = 64,
    parameter int unsigned EVNT_WIDTH       = 32
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        cfg_start,
    input  logic                        cfg_stop,
    input  logic [TIME_WIDTH-1:0]       cfg_time,
    input  logic [EVNT_WIDTH-1:0]       cfg_events,
    output logic [1:0]                  sts_state,
    output logic [TIME_WIDTH-1:0]       sts_time,
    output logic [EVNT_WIDTH-1:0]       sts_events,
`ifdef PHA_DEADTIME_EN
    output logic [TIME_WIDTH-1:0]       sts_dead,
`endif
    output logic [BRAM_ADDR_WIDTH-1:0]  bram_clr_addr,
    output logic                        bram_clr_wren,
    output logic                        s_axis_tready,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid
);

    localparam logic [TIME_WIDTH-1:0] TIME_MAX = '1;
    localparam logic [EVNT_WIDTH-1:0] EVNT_MAX = '1;

    logic [STATE_W-1:0]    state_q, state_d;
    logic [TIME_WIDTH-1:0] time_q, time_d;
    logic [EVNT_WIDTH-1:0] events_q, events_d;
    logic                  start_q, stop_q;
    logic                  start_arm_q, stop_arm_q;
    logic                  start_edge_c, stop_edge_c;
    logic                  run_c, hs_c, time_hit_c, evt_hit_c;
    logic                  sweep_start, sweep_abort, sweep_last_c;

    // Arm flags block a level that was already high when reset released.
    assign start_edge_c = cfg_start & ~start_q & start_arm_q;
    assign stop_edge_c  = cfg_stop  & ~stop_q  & stop_arm_q;

    assign run_c         = (state_q == ST_RUN);
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tvalid = run_c & s_axis_tvalid;
    assign s_axis_tready = run_c ? m_axis_tready : 1'b1;
    assign hs_c          = run_c & s_axis_tvalid & m_axis_tready;

    assign time_hit_c = (cfg_time != '0) && (TIME_WIDTH'(time_q + TIME_WIDTH'(1)) == cfg_time);
    assign evt_hit_c  = (cfg_events != '0) && hs_c &&
                        (EVNT_WIDTH'(events_q + EVNT_WIDTH'(1)) == cfg_events);

    assign sts_state  = state_q;
    assign sts_time   = time_q;
    assign sts_events = events_q;

    pha_clear_sweep #(
        .ADDR_WIDTH (BRAM_ADDR_WIDTH)
    ) u_sweep (
        .clk     (aclk),
        .rst     (areset),
        .start_i (sweep_start),
        .abort_i (sweep_abort),
        .addr_o  (bram_clr_addr),
        .wren_o  (bram_clr_wren),
        .last_c  (sweep_last_c)
    );

`ifdef PHA_DEADTIME_EN
    logic [TIME_WIDTH-1:0] dead_q, dead_d;
    assign sts_dead = dead_q;

    always_comb begin
        dead_d = dead_q;
        if ((state_q == ST_IDLE || state_q == ST_DONE) && start_edge_c && !stop_edge_c) begin
            dead_d = '0;
        end else if (run_c && s_axis_tvalid && !m_axis_tready) begin
            dead_d = TIME_WIDTH'(sat_inc(SAT_W'(dead_q), SAT_W'(TIME_MAX)));
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            dead_q <= '0;
        end else begin
            dead_q <= dead_d;
        end
    end
`endif

    // Next-state and counter update.
    always_comb begin
        state_d     = state_q;
        time_d      = time_q;
        events_d    = events_q;
        sweep_start = 1'b0;
        sweep_abort = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_edge_c && !stop_edge_c) begin
                    state_d     = ST_CLEAR;
                    time_d      = '0;
                    events_d    = '0;
                    sweep_start = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (stop_edge_c) begin
                    state_d     = ST_IDLE;
                    sweep_abort = 1'b1;
                end else if (sweep_last_c) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                time_d = TIME_WIDTH'(sat_inc(SAT_W'(time_q), SAT_W'(TIME_MAX)));
                if (hs_c) begin
                    events_d = EVNT_WIDTH'(sat_inc(SAT_W'(events_q), SAT_W'(EVNT_MAX)));
                end
                if (stop_edge_c || time_hit_c || evt_hit_c) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            time_q      <= '0;
            events_q    <= '0;
            start_q     <= 1'b0;
            stop_q      <= 1'b0;
            start_arm_q <= 1'b0;
            stop_arm_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            time_q      <= time_d;
            events_q    <= events_d;
            start_q     <= cfg_start;
            stop_q      <= cfg_stop;
            start_arm_q <= start_arm_q | ~cfg_start;
            stop_arm_q  <= stop_arm_q | ~cfg_stop;
        end
    end

endmodule
